// File: rtl/voq_buffer_pkg.sv
// Shared constants, arbiter state type and round-robin index helper for the VOQ buffer.
package voq_buffer_pkg;

  localparam int unsigned PORT_NUB_TOTAL   = 4;
  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned VOQ_DEPTH        = 16;
  localparam int unsigned VOQ_AFULL_MARGIN = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Circular successor used by the round-robin search.
  function automatic int unsigned rr_next(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/voq_buffer_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after rr_ptr, wrapping around.
module voq_buffer_rr_arbiter
  import voq_buffer_pkg::*;
#(
  parameter  int unsigned N     = PORT_NUB_TOTAL,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt_c,
  output logic [SEL_W-1:0] gnt_idx_c,
  output logic             gnt_valid_c
);

  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt_c       = '0;
    gnt_idx_c   = '0;
    gnt_valid_c = 1'b0;
    idx         = '0;
    // rr_ptr itself is visited last, so the previous winner has lowest priority.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = SEL_W'(rr_next(32'(rr_ptr), i, N));
      if (!gnt_valid_c && req[idx]) begin
        gnt_valid_c = 1'b1;
        gnt_idx_c   = idx;
        gnt_c[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voq_buffer.sv
// Per-destination beat queues with almost-full back-pressure and a frame-atomic
// round-robin drain through one registered valid/ready output.
module voq_buffer
  import voq_buffer_pkg::*;
#(
  parameter  int unsigned PORT_NUB     = PORT_NUB_TOTAL,
  parameter  int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH        = VOQ_DEPTH,
  parameter  int unsigned AFULL_MARGIN = VOQ_AFULL_MARGIN,
  localparam int unsigned WIDTH_SEL    = $clog2(PORT_NUB),
  localparam int unsigned WIDTH_PORT   = WIDTH_SEL + DATA_WIDTH,
  localparam int unsigned WIDTH_CNT    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [WIDTH_PORT-1:0] data_in,
  input  logic [PORT_NUB-1:0]   done_in,
  output logic                  voq_full_out,
  output logic                  overflow_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [WIDTH_SEL-1:0]  out_port,
  output logic                  out_last
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned FULL_TH = DEPTH - AFULL_MARGIN;

  logic [WIDTH_SEL-1:0]  dest;
  logic [DATA_WIDTH-1:0] payload;
  assign dest    = data_in[WIDTH_PORT-1:DATA_WIDTH];
  assign payload = data_in[DATA_WIDTH-1:0];

  arb_state_e            state_q, state_d;
  logic [WIDTH_SEL-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [PORT_NUB-1:0]   grant_oh_q, grant_oh_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH_SEL-1:0]  out_port_q, out_port_d;
  logic                  voq_full_q, voq_full_d, overflow_q, overflow_d;

  logic                  pop_c;
  logic [PORT_NUB-1:0]   wr_en, frame_req, near_full;
  logic [DATA_WIDTH:0]   head [PORT_NUB];
  logic [DATA_WIDTH:0]   head_sel;
  logic [PORT_NUB-1:0]   gnt_c;
  logic [WIDTH_SEL-1:0]  gnt_idx_c;
  logic                  gnt_valid_c;

  // Advance the locked queue whenever the output register is empty or being drained.
  assign pop_c    = (state_q == ARB_LOCK) && (!out_valid_q || out_ready);
  assign head_sel = head[grant_q];

  for (genvar q = 0; q < PORT_NUB; q++) begin : g_queue
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH_CNT-1:0] cnt_q, cnt_d, frm_q, frm_d;
    logic [DATA_WIDTH:0]  mem_q [DEPTH];
    logic [DATA_WIDTH:0]  head_w;
    logic                 pop;

    // Full check uses the current count: a same-cycle pop does not make room.
    assign wr_en[q]     = valid_in && (dest == WIDTH_SEL'(q)) && (cnt_q != WIDTH_CNT'(DEPTH));
    assign pop          = pop_c && grant_oh_q[q];
    assign head_w       = mem_q[rd_ptr_q];
    assign head[q]      = head_w;
    assign frame_req[q] = (frm_q != '0);
    assign near_full[q] = (cnt_d >= WIDTH_CNT'(FULL_TH));

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en[q]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + WIDTH_CNT'(wr_en[q]) - WIDTH_CNT'(pop);
      frm_d = frm_q + WIDTH_CNT'(wr_en[q] && done_in[q]) - WIDTH_CNT'(pop && head_w[DATA_WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        frm_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        frm_q    <= frm_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[q]) mem_q[wr_ptr_q] <= {done_in[q], payload};
    end
  end

  voq_buffer_rr_arbiter #(.N(PORT_NUB)) u_rr_arbiter (
    .req         (frame_req),
    .rr_ptr      (rr_ptr_q),
    .gnt_c       (gnt_c),
    .gnt_idx_c   (gnt_idx_c),
    .gnt_valid_c (gnt_valid_c)
  );

  always_comb begin
    voq_full_d = |near_full;
    overflow_d = valid_in && !(|wr_en);
  end

  // Arbiter next state and output register.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    out_last_d  = out_last_q;

    if (pop_c) begin
      out_valid_d = 1'b1;
      out_data_d  = head_sel[DATA_WIDTH-1:0];
      out_last_d  = head_sel[DATA_WIDTH];
      out_port_d  = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid_c) begin
          state_d    = ARB_LOCK;
          grant_d    = gnt_idx_c;
          grant_oh_d = gnt_c;
          rr_ptr_d   = gnt_idx_c;
        end
      end
      ARB_LOCK: begin
        if (pop_c && head_sel[DATA_WIDTH]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= WIDTH_SEL'(PORT_NUB - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      out_last_q  <= 1'b0;
      voq_full_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      out_last_q  <= out_last_d;
      voq_full_q  <= voq_full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_port     = out_port_q;
  assign out_last     = out_last_q;
  assign voq_full_out = voq_full_q;
  assign overflow_out = overflow_q;

endmodule
